// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter onto a single memory port, with
// registered outputs and a timeout on reads the memory never acknowledges.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_read,
    input  logic [11:0] p0_read_addr,
    output logic [7:0]  p0_read_data,
    output logic        p0_read_ack,
    input  logic        p0_write,
    input  logic [11:0] p0_write_addr,
    input  logic [7:0]  p0_write_data,
    output logic        p0_write_ack,
    input  logic        p1_read,
    input  logic [11:0] p1_read_addr,
    output logic [7:0]  p1_read_data,
    output logic        p1_read_ack,
    input  logic        p1_write,
    input  logic [11:0] p1_write_addr,
    input  logic [7:0]  p1_write_data,
    output logic        p1_write_ack,
    output logic        mem_read,
    output logic [11:0] mem_read_addr,
    input  logic [7:0]  mem_read_data,
    input  logic        mem_read_ack,
    output logic        mem_write,
    output logic [11:0] mem_write_addr,
    output logic [7:0]  mem_write_data,
    output logic [1:0]  grant,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [1:0]  grant_q, grant_d;
    logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [11:0] mem_read_addr_q, mem_read_addr_d, mem_write_addr_q, mem_write_addr_d;
    logic [7:0]  mem_write_data_q, mem_write_data_d;
    logic [7:0]  p0_read_data_q, p0_read_data_d, p1_read_data_q, p1_read_data_d;
    logic        p0_read_ack_q, p0_read_ack_d, p1_read_ack_q, p1_read_ack_d;
    logic        p0_write_ack_q, p0_write_ack_d, p1_write_ack_q, p1_write_ack_d;
    logic        timeout_q, timeout_d;
    logic        req0, req1, sel, sel_wr, expired;
    logic [7:0]  rdata;

    always_comb begin
        req0             = p0_read | p0_write;
        req1             = p1_read | p1_write;
        sel              = (req0 && req1) ? ~last_q : req1;
        sel_wr           = sel ? p1_write : p0_write;
        expired          = (cnt_q + 8'd1) == 8'(TIMEOUT);
        rdata            = mem_read_ack ? mem_read_data : 8'hFF;
        state_d          = state_q;
        cnt_d            = cnt_q;
        last_d           = last_q;
        grant_d          = grant_q;
        mem_read_d       = 1'b0;
        mem_read_addr_d  = '0;
        mem_write_d      = 1'b0;
        mem_write_addr_d = '0;
        mem_write_data_d = '0;
        p0_read_data_d   = '0;
        p1_read_data_d   = '0;
        p0_read_ack_d    = 1'b0;
        p1_read_ack_d    = 1'b0;
        p0_write_ack_d   = 1'b0;
        p1_write_ack_d   = 1'b0;
        timeout_d        = 1'b0;
        case (state_q)
            IDLE: if (req0 || req1) begin
                state_d          = sel_wr ? WR : RD;
                grant_d          = sel ? 2'b10 : 2'b01;
                last_d           = sel;
                cnt_d            = '0;
                mem_read_d       = !sel_wr;
                mem_read_addr_d  = sel_wr ? 12'h000 : (sel ? p1_read_addr : p0_read_addr);
                mem_write_d      = sel_wr;
                mem_write_addr_d = sel_wr ? (sel ? p1_write_addr : p0_write_addr) : 12'h000;
                mem_write_data_d = sel_wr ? (sel ? p1_write_data : p0_write_data) : 8'h00;
            end
            RD: if (mem_read_ack || expired) begin
                // an ack in the expiring cycle still returns real data
                state_d        = DONE;
                p0_read_ack_d  = grant_q[0];
                p1_read_ack_d  = grant_q[1];
                p0_read_data_d = grant_q[0] ? rdata : 8'h00;
                p1_read_data_d = grant_q[1] ? rdata : 8'h00;
                timeout_d      = !mem_read_ack;
            end else begin
                cnt_d           = cnt_q + 8'd1;
                mem_read_d      = 1'b1;
                mem_read_addr_d = mem_read_addr_q;
            end
            WR: begin
                state_d        = DONE;
                p0_write_ack_d = grant_q[0];
                p1_write_ack_d = grant_q[1];
            end
            DONE: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            last_q           <= 1'b1;
            grant_q          <= '0;
            mem_read_q       <= 1'b0;
            mem_read_addr_q  <= '0;
            mem_write_q      <= 1'b0;
            mem_write_addr_q <= '0;
            mem_write_data_q <= '0;
            p0_read_data_q   <= '0;
            p1_read_data_q   <= '0;
            p0_read_ack_q    <= 1'b0;
            p1_read_ack_q    <= 1'b0;
            p0_write_ack_q   <= 1'b0;
            p1_write_ack_q   <= 1'b0;
            timeout_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            last_q           <= last_d;
            grant_q          <= grant_d;
            mem_read_q       <= mem_read_d;
            mem_read_addr_q  <= mem_read_addr_d;
            mem_write_q      <= mem_write_d;
            mem_write_addr_q <= mem_write_addr_d;
            mem_write_data_q <= mem_write_data_d;
            p0_read_data_q   <= p0_read_data_d;
            p1_read_data_q   <= p1_read_data_d;
            p0_read_ack_q    <= p0_read_ack_d;
            p1_read_ack_q    <= p1_read_ack_d;
            p0_write_ack_q   <= p0_write_ack_d;
            p1_write_ack_q   <= p1_write_ack_d;
            timeout_q        <= timeout_d;
        end
    end

    assign grant          = grant_q;
    assign mem_read       = mem_read_q;
    assign mem_read_addr  = mem_read_addr_q;
    assign mem_write      = mem_write_q;
    assign mem_write_addr = mem_write_addr_q;
    assign mem_write_data = mem_write_data_q;
    assign p0_read_data   = p0_read_data_q;
    assign p1_read_data   = p1_read_data_q;
    assign p0_read_ack    = p0_read_ack_q;
    assign p1_read_ack    = p1_read_ack_q;
    assign p0_write_ack   = p0_write_ack_q;
    assign p1_write_ack   = p1_write_ack_q;
    assign timeout        = timeout_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with TIMEOUT=4; inputs driven
// and outputs sampled on the falling edge.
module tb_mem_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        p0_read = 0, p0_write = 0, p1_read = 0, p1_write = 0;
    logic [11:0] p0_read_addr = 0, p1_read_addr = 0, p0_write_addr = 0, p1_write_addr = 0;
    logic [7:0]  p0_write_data = 0, p1_write_data = 0, mem_read_data = 0;
    logic        mem_read_ack = 0;
    logic [7:0]  p0_read_data, p1_read_data, mem_write_data;
    logic        p0_read_ack, p1_read_ack, p0_write_ack, p1_write_ack;
    logic        mem_read, mem_write, timeout;
    logic [11:0] mem_read_addr, mem_write_addr;
    logic [1:0]  grant;
    int          passed = 0, total = 0;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .p0_read(p0_read), .p0_read_addr(p0_read_addr), .p0_read_data(p0_read_data),
        .p0_read_ack(p0_read_ack), .p0_write(p0_write), .p0_write_addr(p0_write_addr),
        .p0_write_data(p0_write_data), .p0_write_ack(p0_write_ack),
        .p1_read(p1_read), .p1_read_addr(p1_read_addr), .p1_read_data(p1_read_data),
        .p1_read_ack(p1_read_ack), .p1_write(p1_write), .p1_write_addr(p1_write_addr),
        .p1_write_data(p1_write_data), .p1_write_ack(p1_write_ack),
        .mem_read(mem_read), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
        .mem_read_ack(mem_read_ack), .mem_write(mem_write), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .grant(grant), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] acks();
        return {p0_read_ack, p1_read_ack, p0_write_ack, p1_write_ack, timeout, mem_read, mem_write};
    endfunction

    initial begin
        int g = 0, last_c = 0, last_ack = -1;
        logic [1:0] prev_grant = 2'b00;
        cyc(2);
        check("rst_ctl", acks(), 0);
        check("rst_grant", grant, 0);
        check("rst_bus", {mem_read_addr, mem_write_addr, mem_write_data, p0_read_data, p1_read_data}, 0);
        rst = 0;
        cyc();
        // p0 read, memory acks in the second RD cycle
        p0_read = 1; p0_read_addr = 12'h200;
        cyc();
        check("rd_mem_read", mem_read, 1);
        check("rd_addr", mem_read_addr, 12'h200);
        check("rd_grant", grant, 2'b01);
        cyc();
        mem_read_ack = 1; mem_read_data = 8'hA5;
        check("rd_hold", {mem_read, p0_read_ack}, 2'b10);
        cyc();
        check("rd_ack", {p0_read_ack, p1_read_ack, timeout}, 3'b100);
        check("rd_data", p0_read_data, 8'hA5);
        check("rd_grant_done", grant, 2'b01);
        check("rd_dropped", mem_read, 0);
        p0_read = 0; mem_read_ack = 0;
        cyc();
        check("rd_idle", {p0_read_ack, p0_read_data, grant}, 0);
        // p1 write at the top of the address space
        p1_write = 1; p1_write_addr = 12'hFFF; p1_write_data = 8'h3C;
        cyc();
        check("wr_mem_write", {mem_write, mem_write_addr, mem_write_data}, {1'b1, 12'hFFF, 8'h3C});
        check("wr_grant", grant, 2'b10);
        check("wr_no_ack_yet", p1_write_ack, 0);
        cyc();
        check("wr_single", mem_write, 0);
        check("wr_ack", {p0_write_ack, p1_write_ack}, 2'b01);
        p1_write = 0;
        cyc();
        check("wr_idle", {p1_write_ack, grant}, 0);
        // p0 read+write together: write first
        p0_read = 1; p0_read_addr = 12'h0AB; p0_write = 1; p0_write_addr = 12'h0CD; p0_write_data = 8'h11;
        cyc();
        check("rw_write_first", {mem_write, mem_read, mem_write_addr}, {2'b10, 12'h0CD});
        cyc();
        check("rw_write_ack", {p0_write_ack, p0_read_ack}, 2'b10);
        p0_write = 0;
        cyc();
        check("rw_gap", grant, 0);
        cyc();
        check("rw_read", {mem_read, mem_read_addr, grant}, {1'b1, 12'h0AB, 2'b01});
        mem_read_ack = 1; mem_read_data = 8'h5A;
        cyc();
        check("rw_read_ack", {p0_read_ack, p0_read_data}, {1'b1, 8'h5A});
        p0_read = 0; mem_read_ack = 0;
        cyc();
        // p1 read, memory silent: abort after 4 RD cycles
        p1_read = 1; p1_read_addr = 12'h123;
        cyc();
        check("to_rd1", {mem_read, mem_read_addr}, {1'b1, 12'h123});
        cyc(3);
        check("to_rd4", {mem_read, p1_read_ack, timeout}, 3'b100);
        cyc();
        check("to_abort", {mem_read, p1_read_ack, timeout}, 3'b011);
        check("to_data", p1_read_data, 8'hFF);
        check("to_grant", grant, 2'b10);
        p1_read = 0;
        cyc();
        check("to_clear", {timeout, p1_read_ack, p1_read_data}, 0);
        // ack arriving in the expiring cycle wins
        p0_read = 1; p0_read_addr = 12'hABC;
        cyc(4);
        check("aw_rd4", mem_read, 1);
        mem_read_ack = 1; mem_read_data = 8'h77;
        cyc();
        check("aw_ack", {p0_read_ack, timeout, p0_read_data}, {2'b10, 8'h77});
        p0_read = 0;
        // stray acks while not in RD
        cyc(3);
        check("stray_ack", acks(), 0);
        mem_read_ack = 0;
        // reset in the middle of a read
        p1_read = 1; p1_read_addr = 12'h055;
        cyc(2);
        check("mr_in_rd", {mem_read, grant}, 3'b110);
        rst = 1; p1_read = 0;
        #1;
        check("mr_async", {mem_read, grant, mem_read_addr}, 0);
        cyc();
        rst = 0; mem_read_ack = 1; mem_read_data = 8'hEE;
        cyc(2);
        check("mr_no_ack", acks(), 0);
        check("mr_zero", {grant, p1_read_data, mem_read_addr}, 0);
        mem_read_ack = 0;
        // continuous contention right after reset: p0 first, then alternate
        p0_read = 1; p0_read_addr = 12'h010; p1_read = 1; p1_read_addr = 12'h020;
        for (int c = 0; c < 40 && g < 4; c++) begin
            cyc();
            if (grant != 0 && prev_grant == 0) begin
                check("rr_grant", grant, g[0] ? 2'b10 : 2'b01);
                if (g > 0) check("rr_spacing", c - last_c, 3);
                last_c = c; g++;
            end
            prev_grant = grant;
            if (p0_read_ack) begin
                check("rr_p0_data", p0_read_data, 8'h10);
                check("rr_p0_repeat", last_ack != 0, 1);
                last_ack = 0;
            end
            if (p1_read_ack) begin
                check("rr_p1_data", p1_read_data, 8'h20);
                check("rr_p1_repeat", last_ack != 1, 1);
                last_ack = 1;
            end
            mem_read_ack = mem_read; mem_read_data = mem_read_addr[7:0];
        end
        check("rr_count", g, 4);
        p0_read = 0; p1_read = 0; mem_read_ack = 0;
        cyc(8);
        check("end_idle", {acks(), grant}, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
